// File: rtl/bus_bridge_n_if.sv
// CPU/device bus bundle for bus_bridge_n.
//   master : the CPU and device side (drives CPUI_*, DEVI_*, observes CPUO_*, DEVO_*)
//   slave  : the bridge itself
// NDEV sets the width of the per-slot device signals.
interface bus_bridge_n_if #(
  parameter int unsigned NDEV = 2
);
  logic                   CPUI_PrReq;
  logic                   CPUI_PrWe;
  logic [3:0]             CPUI_PrBE;
  logic [31:0]            CPUI_PrAddr;
  logic [31:0]            CPUI_PrWd;
  logic [31:0]            CPUO_PrRd;
  logic                   CPUO_PrAck;
  logic                   CPUO_PrErr;
  logic [7:2]             CPUO_HWInt;
  logic [1:0]             DEVO_Addr;
  logic [31:0]            DEVO_Wd;
  logic [NDEV-1:0]        DEVO_We;
  logic [32*NDEV-1:0]     DEVI_Rd;
  logic [NDEV-1:0]        DEVI_IRQ;

  modport master (
    output CPUI_PrReq, CPUI_PrWe, CPUI_PrBE, CPUI_PrAddr, CPUI_PrWd, DEVI_Rd, DEVI_IRQ,
    input  CPUO_PrRd, CPUO_PrAck, CPUO_PrErr, CPUO_HWInt, DEVO_Addr, DEVO_Wd, DEVO_We
  );

  modport slave (
    input  CPUI_PrReq, CPUI_PrWe, CPUI_PrBE, CPUI_PrAddr, CPUI_PrWd, DEVI_Rd, DEVI_IRQ,
    output CPUO_PrRd, CPUO_PrAck, CPUO_PrErr, CPUO_HWInt, DEVO_Addr, DEVO_Wd, DEVO_We
  );
endinterface

// File: rtl/bus_bridge_n.sv
// CPU-to-device bus bridge with NDEV device slots and an interrupt controller.
// Each access takes three cycles: accept (IDLE), issue to device (ISSUE), respond (RESP).
// Ports:
//   Clock  - rising-edge clock
//   Reset  - asynchronous active-low reset
//   bus    - bus_bridge_n_if.slave: CPU request/response, device strobes, read data, IRQs
// Map: slot i at BASE+16i (words 0..2), control at BASE+16*NDEV: IM, IP (W1C), MODE.
module bus_bridge_n #(
  parameter int unsigned NDEV = 2,
  parameter logic [31:0] BASE = 32'h0000_7f00
) (
  input logic           Clock,
  input logic           Reset,
  bus_bridge_n_if.slave bus
);

  if (NDEV == 0 || NDEV > 6) begin : gen_bad_ndev
    $error("bus_bridge_n: NDEV must be in 1..6");
  end

  localparam logic [31:0] DevSpan  = 32'(16 * NDEV);
  localparam logic [27:0] CtrlSlot = 28'(NDEV);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q;
  logic [31:0] addr_q, wd_q, rd_q, rd_d;
  logic [3:0]  be_q;
  logic        we_q, ack_q, err_q;
  logic [5:0]  im_q, ip_q, ip_d, mode_q, raw_q, raw, w1c;

  logic [31:0]     off, dev_rd, ctrl_rd;
  logic [2:0]      slot;
  logic            dev_hit, ctrl_hit, acc_err, issue_wr, ctrl_wr;
  logic [NDEV-1:0] dev_we;
  logic            unused_off;

  // Decode of the registered request.
  always_comb begin
    off      = addr_q - BASE;  // addresses below BASE wrap high and miss every window
    slot     = off[6:4];
    dev_hit  = (off < DevSpan) && (off[3:2] != 2'd3);
    ctrl_hit = (off[31:4] == CtrlSlot) && (off[3:2] != 2'd3);
    acc_err  = !(dev_hit || ctrl_hit) || (we_q && (be_q != 4'hF));
    issue_wr = (state_q == StIssue) && we_q && !acc_err;
    ctrl_wr  = issue_wr && ctrl_hit;

    dev_rd = '0;
    dev_we = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (slot == 3'(i)) begin
        dev_rd    = bus.DEVI_Rd[32*i +: 32];
        dev_we[i] = issue_wr && dev_hit;
      end
    end

    case (off[3:2])
      2'd0:    ctrl_rd = {26'b0, im_q};
      2'd1:    ctrl_rd = {26'b0, ip_q};
      2'd2:    ctrl_rd = {26'b0, mode_q};
      default: ctrl_rd = '0;
    endcase

    if (acc_err || we_q) rd_d = '0;
    else if (dev_hit)    rd_d = dev_rd;
    else                 rd_d = ctrl_rd;
  end

  assign unused_off = ^off[1:0];

  // Interrupt next state: level bits track the input; edge bits latch rising edges and
  // clear on W1C, with a same-cycle edge taking priority.
  always_comb begin
    raw            = '0;
    raw[NDEV-1:0]  = bus.DEVI_IRQ;
    w1c            = (ctrl_wr && off[3:2] == 2'd1) ? wd_q[5:0] : 6'b0;
    ip_d           = (~mode_q & raw) | (mode_q & ((raw & ~raw_q) | (ip_q & ~w1c)));
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      raw_q  <= '0;
      ip_q   <= '0;
      mode_q <= '0;
      im_q   <= 6'h3F;
    end else begin
      raw_q <= raw;
      ip_q  <= ip_d;
      if (ctrl_wr && off[3:2] == 2'd0) im_q   <= wd_q[5:0];
      if (ctrl_wr && off[3:2] == 2'd2) mode_q <= wd_q[5:0];
    end
  end

  // Access FSM with registered response outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_q <= 1'b0;
          if (bus.CPUI_PrReq) begin
            addr_q  <= bus.CPUI_PrAddr;
            wd_q    <= bus.CPUI_PrWd;
            be_q    <= bus.CPUI_PrBE;
            we_q    <= bus.CPUI_PrWe;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          rd_q    <= rd_d;
          err_q   <= acc_err;
          ack_q   <= 1'b1;
          state_q <= StResp;
        end
        StResp: begin
          ack_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.DEVO_Addr  = (state_q == StIssue) ? off[3:2] : 2'b0;
  assign bus.DEVO_Wd    = (state_q == StIssue) ? wd_q : 32'b0;
  assign bus.DEVO_We    = dev_we;
  assign bus.CPUO_PrRd  = rd_q;
  assign bus.CPUO_PrAck = ack_q;
  assign bus.CPUO_PrErr = err_q;
  assign bus.CPUO_HWInt = ip_q & im_q;

endmodule

// File: tb/tb_bus_bridge_n.sv
// Self-checking bench for bus_bridge_n: directed scenarios plus randomized accesses,
// compared against an address-map / register model kept in the bench.
module tb_bus_bridge_n;
  localparam int unsigned NDEV = 2;
  localparam logic [31:0] BASE = 32'h0000_7f00;
  localparam logic [31:0] CTRL = BASE + 32'(16 * NDEV);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_bridge_n_if #(.NDEV(NDEV)) bus ();

  bus_bridge_n #(.NDEV(NDEV), .BASE(BASE)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [5:0]  m_im, m_ip, m_mode, m_raw_q;
  bit          in_reset;
  logic [5:0]  p_w1c, p_wval;
  bit          p_im_wr, p_mode_wr;
  logic [31:0] dev_rd [NDEV];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_rd();
    for (int i = 0; i < NDEV; i++) bus.DEVI_Rd[32*i +: 32] = dev_rd[i];
  endtask

  task automatic model_reset();
    m_im = 6'h3F; m_ip = '0; m_mode = '0; m_raw_q = '0;
    p_w1c = '0; p_wval = '0; p_im_wr = 0; p_mode_wr = 0;
  endtask

  // Advance one clock; model follows the interrupt rules, then HWInt is compared.
  task automatic tick();
    logic [5:0] raw, nip;
    raw = 6'(bus.DEVI_IRQ);
    if (!in_reset) begin
      for (int j = 0; j < 6; j++) begin
        if (!m_mode[j])                  nip[j] = raw[j];
        else if (raw[j] && !m_raw_q[j])  nip[j] = 1'b1;
        else if (p_w1c[j])               nip[j] = 1'b0;
        else                             nip[j] = m_ip[j];
      end
      m_ip    = nip;
      m_raw_q = raw;
      if (p_im_wr)   m_im   = p_wval;
      if (p_mode_wr) m_mode = p_wval;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("hwint", 32'(bus.CPUO_HWInt), 32'(m_ip & m_im));
  endtask

  // kind: 0 = device slot, 1 = control window, 2 = unmapped
  task automatic classify(input logic [31:0] a, output int kind, output int idx,
                          output int word);
    logic [31:0] off;
    int unsigned rem;
    off  = a - BASE;
    rem  = off % 16;
    word = int'(rem / 4);
    idx  = 0;
    if (off < 32'(16 * NDEV) && rem < 12) begin
      kind = 0;
      idx  = int'(off / 16);
    end else if (off / 16 == 32'(NDEV) && rem < 12) begin
      kind = 1;
    end else begin
      kind = 2;
    end
  endtask

  // One full access starting in IDLE at a falling edge. issue_irq >= 0 sets DEVI_IRQ
  // for the ISSUE cycle.
  task automatic access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input int issue_irq);
    int kind, idx, word;
    bit err;
    logic [NDEV-1:0] exp_we;
    logic [31:0] exp_rd;
    classify(addr, kind, idx, word);
    err    = (kind == 2) || (we && be != 4'hF);
    exp_we = '0;
    if (we && !err && kind == 0) exp_we[idx] = 1'b1;

    bus.CPUI_PrReq  = 1'b1;
    bus.CPUI_PrWe   = we;
    bus.CPUI_PrBE   = be;
    bus.CPUI_PrAddr = addr;
    bus.CPUI_PrWd   = wd;
    tick();
    // ISSUE: scramble the request inputs, they must be ignored now.
    bus.CPUI_PrReq  = 1'($urandom_range(0, 1));
    bus.CPUI_PrWe   = 1'($urandom_range(0, 1));
    bus.CPUI_PrBE   = 4'($urandom);
    bus.CPUI_PrAddr = $urandom;
    bus.CPUI_PrWd   = $urandom;
    if (issue_irq >= 0) bus.DEVI_IRQ = NDEV'(issue_irq);
    check_eq("issue_we", 32'(bus.DEVO_We), 32'(exp_we));
    check_eq("issue_ack", 32'(bus.CPUO_PrAck), 32'd0);
    if (kind == 0 && !err) check_eq("issue_addr", 32'(bus.DEVO_Addr), 32'(word));
    if (kind == 0 && !err && we) check_eq("issue_wd", bus.DEVO_Wd, wd);

    if (we || err)      exp_rd = '0;
    else if (kind == 0) exp_rd = dev_rd[idx];
    else if (word == 0) exp_rd = 32'(m_im);
    else if (word == 1) exp_rd = 32'(m_ip);
    else                exp_rd = 32'(m_mode);

    if (we && !err && kind == 1) begin
      p_wval = wd[5:0];
      if (word == 0)      p_im_wr   = 1;
      else if (word == 1) p_w1c     = wd[5:0];
      else                p_mode_wr = 1;
    end
    tick();
    p_w1c = '0; p_im_wr = 0; p_mode_wr = 0;
    // RESP
    check_eq("resp_ack", 32'(bus.CPUO_PrAck), 32'd1);
    check_eq("resp_err", 32'(bus.CPUO_PrErr), 32'(err));
    check_eq("resp_rd", bus.CPUO_PrRd, exp_rd);
    check_eq("resp_we", 32'(bus.DEVO_We), 32'd0);
    bus.CPUI_PrReq = 1'($urandom_range(0, 1));
    tick();
    // Back in IDLE: response held, strobe gone.
    check_eq("idle_ack", 32'(bus.CPUO_PrAck), 32'd0);
    check_eq("hold_rd", bus.CPUO_PrRd, exp_rd);
    check_eq("hold_err", 32'(bus.CPUO_PrErr), 32'(err));
    bus.CPUI_PrReq = 1'b0;
  endtask

  initial begin
    in_reset = 1;
    model_reset();
    bus.CPUI_PrReq = 0; bus.CPUI_PrWe = 0; bus.CPUI_PrBE = 0;
    bus.CPUI_PrAddr = 0; bus.CPUI_PrWd = 0; bus.DEVI_IRQ = '0;
    for (int i = 0; i < NDEV; i++) dev_rd[i] = 32'h1000 + 32'(i);
    drive_rd();
    repeat (2) @(negedge clk);
    check_eq("rst_ack", 32'(bus.CPUO_PrAck), 32'd0);
    check_eq("rst_err", 32'(bus.CPUO_PrErr), 32'd0);
    check_eq("rst_rd", bus.CPUO_PrRd, 32'd0);
    check_eq("rst_we", 32'(bus.DEVO_We), 32'd0);
    check_eq("rst_hwint", 32'(bus.CPUO_HWInt), 32'd0);
    rst_n = 1'b1;
    in_reset = 0;

    // Write to slot 1 word 1, accepted on the first edge after reset release.
    access(1, 4'hF, 32'h7f14, 32'h1234, -1);
    // Read slot 0 word 2.
    dev_rd[0] = 32'hCAFE; drive_rd();
    access(0, 4'hF, 32'h7f08, 32'h0, -1);
    // Partial write and unmapped word.
    access(1, 4'h3, 32'h7f00, 32'hFFFF_FFFF, -1);
    access(0, 4'hF, 32'h7f0c, 32'h0, -1);
    access(1, 4'hF, CTRL + 32'hC, 32'h3F, -1);

    // Edge mode on bit 0.
    access(1, 4'hF, CTRL + 8, 32'h1, -1);
    bus.DEVI_IRQ = 2'b01; tick();
    bus.DEVI_IRQ = 2'b00; tick(); tick();
    check_eq("edge_held", 32'(bus.CPUO_HWInt[2]), 32'd1);
    access(1, 4'hF, CTRL + 4, 32'h1, -1);
    check_eq("edge_clr", 32'(bus.CPUO_HWInt[2]), 32'd0);
    bus.DEVI_IRQ = 2'b01; tick();
    bus.DEVI_IRQ = 2'b00; tick();
    access(1, 4'hF, CTRL + 4, 32'h1, 1);
    check_eq("edge_wins", 32'(bus.CPUO_HWInt[2]), 32'd1);
    bus.DEVI_IRQ = 2'b00; tick();

    // Level mode with mask.
    access(1, 4'hF, CTRL + 8, 32'h0, -1);
    access(1, 4'hF, CTRL + 0, 32'h2, -1);
    bus.DEVI_IRQ = 2'b11; tick();
    check_eq("lvl_mask", 32'(bus.CPUO_HWInt), 32'h2);
    bus.DEVI_IRQ = 2'b01; tick();
    check_eq("lvl_drop", 32'(bus.CPUO_HWInt), 32'h0);
    access(0, 4'hF, CTRL + 0, 32'h0, -1);

    // Randomized accesses.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = BASE - 32'($urandom_range(1, 8));
      else               a = BASE + 32'($urandom_range(0, 16 * (NDEV + 1) + 3));
      for (int i = 0; i < NDEV; i++) dev_rd[i] = $urandom;
      drive_rd();
      bus.DEVI_IRQ = NDEV'($urandom);
      if ($urandom_range(0, 3) == 0) tick();
      access(1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
             a, $urandom,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    // Reset in the middle of a write's ISSUE cycle.
    bus.DEVI_IRQ = '0;
    access(1, 4'hF, CTRL + 0, 32'h0, -1);
    bus.CPUI_PrReq = 1; bus.CPUI_PrWe = 1; bus.CPUI_PrBE = 4'hF;
    bus.CPUI_PrAddr = BASE; bus.CPUI_PrWd = 32'h55;
    tick();
    check_eq("abort_pre_we", 32'(bus.DEVO_We), 32'd1);
    rst_n = 1'b0;
    in_reset = 1;
    model_reset();
    bus.CPUI_PrReq = 0;
    #1;
    check_eq("abort_we", 32'(bus.DEVO_We), 32'd0);
    check_eq("abort_ack", 32'(bus.CPUO_PrAck), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("abort_ack_r", 32'(bus.CPUO_PrAck), 32'd0);
      check_eq("abort_we_r", 32'(bus.DEVO_We), 32'd0);
    end
    rst_n = 1'b1;
    in_reset = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("post_ack", 32'(bus.CPUO_PrAck), 32'd0);
      check_eq("post_we", 32'(bus.DEVO_We), 32'd0);
    end
    access(0, 4'hF, CTRL + 0, 32'h0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
